// File: rtl/operand_forward_stage_if.sv
// Operand-forwarding stage bus: ID-stage request, pipeline results coming
// back for forwarding, and the registered ID/EX + tag-chain outputs.
//
// Flow control: ID_VALID marks a real instruction in ID. There is no ready
// signal; STALL is the back-pressure. While STALL=1 the driver must hold the
// same ID instruction, and it is accepted on the first edge with STALL=0.
interface operand_forward_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic [DW-1:0] PA;
    logic [DW-1:0] PB;
    logic          ID_VALID;
    logic [AW-1:0] ID_RD;
    logic          ID_LE;
    logic          ID_LOAD;
    logic          FLUSH;
    logic [DW-1:0] EX_RES;
    logic [DW-1:0] MEM_RES;
    logic [DW-1:0] WB_RES;

    logic [DW-1:0] EX_A;
    logic [DW-1:0] EX_B;
    logic          EX_VALID;
    logic [AW-1:0] EX_RD;
    logic          EX_LE;
    logic          EX_LOAD;
    logic [AW-1:0] MEM_RD;
    logic          MEM_LE;
    logic [AW-1:0] WB_RD;
    logic          WB_LE;
    logic [1:0]    FWD_A;
    logic [1:0]    FWD_B;
    logic          STALL;

    modport master (
        output RA, RB, PA, PB, ID_VALID, ID_RD, ID_LE, ID_LOAD, FLUSH,
               EX_RES, MEM_RES, WB_RES,
        input  EX_A, EX_B, EX_VALID, EX_RD, EX_LE, EX_LOAD,
               MEM_RD, MEM_LE, WB_RD, WB_LE, FWD_A, FWD_B, STALL
    );

    modport slave (
        input  RA, RB, PA, PB, ID_VALID, ID_RD, ID_LE, ID_LOAD, FLUSH,
               EX_RES, MEM_RES, WB_RES,
        output EX_A, EX_B, EX_VALID, EX_RD, EX_LE, EX_LOAD,
               MEM_RD, MEM_LE, WB_RD, WB_LE, FWD_A, FWD_B, STALL
    );
endinterface

// File: rtl/operand_forward_stage.sv
// Operand forwarding / load-use stall stage between the register file and EX.
// Resolves RAW hazards from EX/MEM/WB, inserts one bubble per load-use, and
// carries the destination tag chain whose WB end writes the register file.
module operand_forward_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic                    CLK,
    input logic                    RST,
    operand_forward_stage_if.slave bus
);
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    logic [DW-1:0] ex_a_q, ex_a_d;
    logic [DW-1:0] ex_b_q, ex_b_d;
    logic          ex_valid_q, ex_valid_d;
    logic [AW-1:0] ex_rd_q, ex_rd_d;
    logic          ex_le_q, ex_le_d;
    logic          ex_load_q, ex_load_d;
    logic [AW-1:0] mem_rd_q, mem_rd_d;
    logic          mem_le_q, mem_le_d;
    logic [AW-1:0] wb_rd_q, wb_rd_d;
    logic          wb_le_q, wb_le_d;

    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] opnd_a, opnd_b;
    logic          hazard, stall;

    // Youngest in-flight writer wins; a load still in EX has no data yet.
    // Source register 0 never matches, so R0 writers are never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic          e_le, input logic [AW-1:0] e_rd, input logic e_load,
        input logic          m_le, input logic [AW-1:0] m_rd,
        input logic          w_le, input logic [AW-1:0] w_rd
    );
        if (src == '0)                          return SEL_RF;
        else if (e_le && e_rd == src && !e_load) return SEL_EX;
        else if (m_le && m_rd == src)           return SEL_MEM;
        else if (w_le && w_rd == src)           return SEL_WB;
        else                                    return SEL_RF;
    endfunction

    // WB must be forwarded: the register file writes on the same edge, so
    // PA/PB still carry the old contents this cycle.
    function automatic logic [DW-1:0] fwd_data(
        input logic [1:0]    sel,
        input logic [AW-1:0] src,
        input logic [DW-1:0] rf, input logic [DW-1:0] ex,
        input logic [DW-1:0] mem, input logic [DW-1:0] wb
    );
        if (src == '0) return '0;
        case (sel)
            SEL_EX:  return ex;
            SEL_MEM: return mem;
            SEL_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    // Forward selection, load-use detection and next-state for ID/EX and the tag chain.
    always_comb begin
        fwd_a  = fwd_sel(bus.RA, ex_le_q, ex_rd_q, ex_load_q, mem_le_q, mem_rd_q, wb_le_q, wb_rd_q);
        fwd_b  = fwd_sel(bus.RB, ex_le_q, ex_rd_q, ex_load_q, mem_le_q, mem_rd_q, wb_le_q, wb_rd_q);
        opnd_a = fwd_data(fwd_a, bus.RA, bus.PA, bus.EX_RES, bus.MEM_RES, bus.WB_RES);
        opnd_b = fwd_data(fwd_b, bus.RB, bus.PB, bus.EX_RES, bus.MEM_RES, bus.WB_RES);

        hazard = bus.ID_VALID && ex_load_q && ex_le_q && (ex_rd_q != '0) &&
                 ((ex_rd_q == bus.RA) || (ex_rd_q == bus.RB));
        // A taken branch squashes the dependent instruction, so no stall is needed.
        stall  = hazard && !bus.FLUSH;

        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        ex_le_d    = 1'b0;
        ex_load_d  = 1'b0;
        if (!(bus.FLUSH || stall)) begin
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_valid_d = bus.ID_VALID;
            ex_rd_d    = bus.ID_RD;
            ex_le_d    = bus.ID_LE && bus.ID_VALID;
            ex_load_d  = bus.ID_LOAD && bus.ID_VALID;
        end

        // The tag chain always advances; stalls only affect what enters EX.
        mem_rd_d = ex_rd_q;
        mem_le_d = ex_le_q;
        wb_rd_d  = mem_rd_q;
        wb_le_d  = mem_le_q;
    end

    // Pipeline registers; reset clears the bubble and every tag so no write follows reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_le_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            mem_rd_q   <= '0;
            mem_le_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_le_q    <= 1'b0;
        end else begin
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_le_q    <= ex_le_d;
            ex_load_q  <= ex_load_d;
            mem_rd_q   <= mem_rd_d;
            mem_le_q   <= mem_le_d;
            wb_rd_q    <= wb_rd_d;
            wb_le_q    <= wb_le_d;
        end
    end

    assign bus.EX_A     = ex_a_q;
    assign bus.EX_B     = ex_b_q;
    assign bus.EX_VALID = ex_valid_q;
    assign bus.EX_RD    = ex_rd_q;
    assign bus.EX_LE    = ex_le_q;
    assign bus.EX_LOAD  = ex_load_q;
    assign bus.MEM_RD   = mem_rd_q;
    assign bus.MEM_LE   = mem_le_q;
    assign bus.WB_RD    = wb_rd_q;
    assign bus.WB_LE    = wb_le_q;
    assign bus.FWD_A    = fwd_a;
    assign bus.FWD_B    = fwd_b;
    assign bus.STALL    = stall;
endmodule

// File: doc/operand_forward_stage.md
Name: operand_forward_stage

Overview:
- Sits directly downstream of the 32x32 register file. Consumes its read ports PA/PB and read addresses RA/RB.
- Resolves RAW hazards by forwarding EX/MEM/WB results, and stalls on load-use.
- Registers the resolved operands into the ID/EX pipeline register.
- Carries the destination-tag chain EX->MEM->WB. Its WB_RD/WB_LE outputs drive the register file write address and enable.

Parameters:
- DW, 32, operand/data width.
- AW, 5, register address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RA  in  AW  ID-stage source A address (same as register file RA).
- RB  in  AW  ID-stage source B address (same as register file RB).
- PA  in  DW  register file port A data.
- PB  in  DW  register file port B data.
- ID_VALID  in  1  ID holds a real instruction.
- ID_RD  in  AW  ID destination register.
- ID_LE  in  1  ID instruction writes a register.
- ID_LOAD  in  1  ID instruction is a load.
- FLUSH  in  1  squash the ID instruction (branch taken).
- EX_RES  in  DW  EX-stage result, valid combinationally this cycle.
- MEM_RES  in  DW  MEM-stage result, load data included.
- WB_RES  in  DW  WB-stage write data (also drives register file PD).
- EX_A  out  DW  registered operand A.
- EX_B  out  DW  registered operand B.
- EX_VALID, EX_RD, EX_LE, EX_LOAD  out  1/AW/1/1  ID/EX tag fields.
- MEM_RD, MEM_LE  out  AW/1  EX/MEM tag.
- WB_RD, WB_LE  out  AW/1  MEM/WB tag; drive register file RD/EN.
- FWD_A, FWD_B  out  2  combinational select: 0=regfile, 1=EX, 2=MEM, 3=WB.
- STALL  out  1  combinational; holds PC and IF/ID externally.

Behaviour:
- Reset (RST=1 at edge): EX_A=EX_B=0; all VALID/LE/LOAD=0; all RD=0. STALL=0 and FWD_*=0 follow combinationally.
- RST has priority over FLUSH and STALL.
- Forward select for A (B identical with RB/PB):
  - RA=0 -> 0, and the operand is forced to 0.
  - Else EX_LE & EX_RD==RA & !EX_LOAD -> 1 (EX_RES).
  - Else MEM_LE & MEM_RD==RA -> 2 (MEM_RES).
  - Else WB_LE & WB_RD==RA -> 3 (WB_RES).
  - Else 0 (PA).
  - Priority is EX > MEM > WB, so the youngest writer wins.
  - WB forwarding is mandatory: the register file writes on the same edge, so PA still shows the old value.
- Load-use hazard: ID_VALID & EX_LOAD & EX_LE & EX_RD!=0 & (EX_RD==RA | EX_RD==RB).
- STALL = hazard & !FLUSH.
- ID/EX update each edge:
  - FLUSH or STALL: load a bubble (VALID=LE=LOAD=0, RD=0). EX_A/EX_B are don't-care but loaded with 0.
  - Otherwise: EX_A/EX_B take the forwarded operands; VALID=ID_VALID; LE=ID_LE&ID_VALID; LOAD=ID_LOAD&ID_VALID; RD=ID_RD.
- Tag chain: MEM <= EX and WB <= MEM every edge, unconditionally (not held by STALL or FLUSH).
- Latency: 1 cycle, ID to EX_*. A stalled instruction re-presents next cycle with the load now in MEM, so it forwards from MEM_RES (select 2). Exactly one bubble per load-use.
- RD=0 writers never match; R0 is never forwarded.
- Both sources may hit different stages in the same cycle; A and B resolve independently.
- RA==RB: both get the same source.
- Reset mid-stall drops the bubble and all tags; no write reaches the register file on the cycle after reset.

Test Plan:
- Reset: RST=1 with arbitrary inputs -> next cycle all outputs 0, STALL=0, WB_LE=0.
- EX forward: prior instr in EX with RD=5, LE=1, EX_RES=0xDEADBEEF; ID RA=5, PA=0x11 -> FWD_A=1; EX_A=0xDEADBEEF after edge.
- Priority: EX writes R7=0xA, MEM writes R7=0xB, WB writes R7=0xC; RB=7 -> FWD_B=1, EX_B=0xA. Remove the EX writer -> FWD_B=2, EX_B=0xB.
- Load-use: load to R3 in EX; ID RA=3 -> STALL=1 and a bubble enters EX. Next cycle, with MEM_RES=0x1234: STALL=0, FWD_A=2, EX_A=0x1234.
- R0 and WB forwarding:
  - WB_LE=1, WB_RD=0, WB_RES=0xFF; RA=0 -> FWD_A=0, EX_A=0.
  - WB_RD=9, WB_RES=0x55; RB=9 -> FWD_B=3, EX_B=0x55.
- FLUSH during hazard: load-use condition present with FLUSH=1 -> STALL=0 and bubble loaded. The load still advances to MEM and then WB, with WB_LE=1 two cycles later.
